// File: rtl/run_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_controller_pkg
// Description : Shared types and constants for the run controller: state
//               encoding, bus widths and default speed / frame constants.
// Revision    : 1.0 - initial release
// ============================================================================
package run_controller_pkg;

  // Fixed-point scale of the speed value (pixels per frame x SPEED_SCALE).
  localparam int unsigned SPEED_SCALE = 1024;

  localparam int unsigned DEF_INIT_SPEED     = 6 * SPEED_SCALE;
  localparam int unsigned DEF_MAX_SPEED      = 13 * SPEED_SCALE;
  localparam int unsigned DEF_ACCEL          = 1;
  localparam int unsigned DEF_CLEAR_FRAMES   = 180;
  localparam int unsigned DEF_LOCKOUT_FRAMES = 60;

  localparam int SPEED_W = 15;
  localparam int SCORE_W = 17;
  localparam int STATE_W = 2;

  // Code 2'd3 is never produced; the controller treats it as idle.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_CRASHED = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/run_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : run_controller_if
// Description : Frame-event and status bundle of the run controller.
//               master : game logic side (drives update/start/collide/score)
//               slave  : run controller (drives speed, meter_rst,
//                        obstacles_en, state, high_score, new_high)
// Revision    : 1.0 - initial release
// ============================================================================
interface run_controller_if;
  import run_controller_pkg::*;

  logic               update;
  logic               start;
  logic               collide;
  logic [SCORE_W-1:0] score;
  logic [SPEED_W-1:0] speed;
  logic               meter_rst;
  logic               obstacles_en;
  logic [STATE_W-1:0] state;
  logic [SCORE_W-1:0] high_score;
  logic               new_high;

  modport master (
    output update, start, collide, score,
    input  speed, meter_rst, obstacles_en, state, high_score, new_high
  );

  modport slave (
    input  update, start, collide, score,
    output speed, meter_rst, obstacles_en, state, high_score, new_high
  );

endinterface
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_timer
// Description : Saturating frame counter. Counts inc_i pulses up to
//               MAX_COUNT and holds there; clr_i returns it to zero.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               clr_i        - clear (wins over inc_i)
//               inc_i        - count one frame
//               done_o       - current count equals MAX_COUNT
//               done_next_o  - count will equal MAX_COUNT after this edge
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timer #(
  parameter int unsigned MAX_COUNT = 180
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o,
  output logic done_next_o
);

  localparam int W = $clog2(MAX_COUNT + 1);
  localparam logic [W-1:0] c_max = W'(MAX_COUNT);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != c_max)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o      = (count_q == c_max);
  // Lookahead lets the owner register a flag that changes on the same edge
  // as the counter itself.
  assign done_next_o = (count_d == c_max);

endmodule
`default_nettype wire

// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module      : run_controller
// Description : Endless-runner game state machine. Starts runs, ramps the
//               scroll speed, enables obstacles after a grace period, detects
//               crashes, keeps the high score and enforces a restart lockout.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - run_controller_if.slave (frame events in,
//                          registered speed/status out)
// Revision    : 1.0 - initial release
// ============================================================================
module run_controller
  import run_controller_pkg::*;
#(
  parameter int unsigned INIT_SPEED     = DEF_INIT_SPEED,
  parameter int unsigned MAX_SPEED      = DEF_MAX_SPEED,
  parameter int unsigned ACCEL          = DEF_ACCEL,
  parameter int unsigned CLEAR_FRAMES   = DEF_CLEAR_FRAMES,
  parameter int unsigned LOCKOUT_FRAMES = DEF_LOCKOUT_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  run_controller_if.slave  bus
);

  localparam logic [SPEED_W-1:0] c_init_speed = SPEED_W'(INIT_SPEED);
  // One bit wider than the speed so the add cannot wrap before the clamp.
  localparam logic [SPEED_W:0]   c_max_speed  = (SPEED_W + 1)'(MAX_SPEED);
  localparam logic [SPEED_W:0]   c_accel      = (SPEED_W + 1)'(ACCEL);

  state_e             state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               meter_rst_q, meter_rst_d;
  logic               obstacles_en_q, obstacles_en_d;
  logic [SCORE_W-1:0] high_score_q, high_score_d;
  logic               new_high_q, new_high_d;

  logic               w_clr_inc, w_clr_clr, w_clr_done, w_clr_done_next;
  logic               w_lock_inc, w_lock_clr, w_lock_done, w_lock_done_next;
  logic [SPEED_W:0]   w_speed_sum;
  logic               w_unused;

  assign w_speed_sum = {1'b0, speed_q} + c_accel;

  // Grace period at the start of each run before obstacles may spawn.
  frame_timer #(.MAX_COUNT(CLEAR_FRAMES)) u_clear_timer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (w_clr_clr),
    .inc_i       (w_clr_inc),
    .done_o      (w_clr_done),
    .done_next_o (w_clr_done_next)
  );

  // Frames since the last crash; restart is refused until it saturates.
  frame_timer #(.MAX_COUNT(LOCKOUT_FRAMES)) u_lockout_timer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (w_lock_clr),
    .inc_i       (w_lock_inc),
    .done_o      (w_lock_done),
    .done_next_o (w_lock_done_next)
  );

  assign w_unused = w_clr_done ^ w_lock_done_next;

  always_comb begin
    state_d      = state_q;
    speed_d      = speed_q;
    meter_rst_d  = 1'b0;
    high_score_d = high_score_q;
    new_high_d   = new_high_q;
    w_clr_inc    = 1'b0;
    w_clr_clr    = 1'b0;
    w_lock_inc   = 1'b0;
    w_lock_clr   = 1'b0;

    case (state_q)
      ST_RUNNING: begin
        if (bus.update) begin
          if (bus.collide) begin
            // Collision outranks a simultaneous start press.
            state_d    = ST_CRASHED;
            speed_d    = '0;
            w_lock_clr = 1'b1;
            if (bus.score > high_score_q) begin
              high_score_d = bus.score;
              new_high_d   = 1'b1;
            end else begin
              new_high_d   = 1'b0;
            end
          end else begin
            speed_d   = (w_speed_sum > c_max_speed) ? c_max_speed[SPEED_W-1:0]
                                                    : w_speed_sum[SPEED_W-1:0];
            w_clr_inc = 1'b1;
          end
        end
      end

      ST_CRASHED: begin
        if (bus.update) begin
          w_lock_inc = 1'b1;
          // Lockout is judged on the count before this update's increment.
          if (bus.start && w_lock_done) begin
            state_d     = ST_RUNNING;
            speed_d     = c_init_speed;
            meter_rst_d = 1'b1;
            w_clr_clr   = 1'b1;
            new_high_d  = 1'b0;
          end
        end
      end

      default: begin
        // Idle, and the unused code 3 which behaves exactly like idle.
        speed_d = '0;
        if (bus.update && bus.start) begin
          state_d     = ST_RUNNING;
          speed_d     = c_init_speed;
          meter_rst_d = 1'b1;
          w_clr_clr   = 1'b1;
          new_high_d  = 1'b0;
        end
      end
    endcase
  end

  assign obstacles_en_d = (state_d == ST_RUNNING) && w_clr_done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      speed_q        <= '0;
      meter_rst_q    <= 1'b0;
      obstacles_en_q <= 1'b0;
      high_score_q   <= '0;
      new_high_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      speed_q        <= speed_d;
      meter_rst_q    <= meter_rst_d;
      obstacles_en_q <= obstacles_en_d;
      high_score_q   <= high_score_d;
      new_high_q     <= new_high_d;
    end
  end

  assign bus.speed        = speed_q;
  assign bus.meter_rst    = meter_rst_q;
  assign bus.obstacles_en = obstacles_en_q;
  assign bus.state        = state_q;
  assign bus.high_score   = high_score_q;
  assign bus.new_high     = new_high_q;

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_controller
// Description : Directed self-checking bench for run_controller. Each step
//               pushes the expected output vector {state, speed, meter_rst,
//               obstacles_en, high_score, new_high} onto a scoreboard queue;
//               the vector is popped and compared one clock later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_controller;
  import run_controller_pkg::*;

  typedef logic [36:0] obs_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  run_controller_if bus ();

  run_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic obs_t mk(input int st, input int spd, input logic mr,
                              input logic ob, input int hs, input logic nh);
    return {2'(st), 15'(spd), mr, ob, 17'(hs), nh};
  endfunction

  function automatic obs_t observed();
    return {bus.state, bus.speed, bus.meter_rst, bus.obstacles_en,
            bus.high_score, bus.new_high};
  endfunction

  task automatic check_pop();
    obs_t  e;
    string t;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=entry", observed());
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (observed() === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, observed(), e);
      end
    end
  endtask

  // Drive one clock of stimulus, record the expectation, check after the edge.
  task automatic cycle(input logic r, input logic u, input logic s,
                       input logic c, input int sc, input string tag,
                       input obs_t e);
    @(negedge clk);
    rst         = r;
    bus.update  = u;
    bus.start   = s;
    bus.collide = c;
    bus.score   = 17'(sc);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    int spd;
    rst         = 1'b1;
    bus.update  = 1'b0;
    bus.start   = 1'b0;
    bus.collide = 1'b0;
    bus.score   = '0;

    // Reset state, and reset beating a start press.
    cycle(1, 0, 0, 0, 0, "reset", mk(0, 0, 0, 0, 0, 0));
    cycle(1, 1, 1, 0, 0, "reset_vs_start", mk(0, 0, 0, 0, 0, 0));

    // Start a run; meter_rst for exactly one cycle.
    cycle(0, 1, 1, 0, 0, "start", mk(1, 6144, 1, 0, 0, 0));
    cycle(0, 0, 0, 0, 0, "meter_rst_drop", mk(1, 6144, 0, 0, 0, 0));

    // Events without update change nothing.
    cycle(0, 0, 1, 1, 0, "noupd_start_collide", mk(1, 6144, 0, 0, 0, 0));
    cycle(0, 0, 0, 1, 0, "noupd_collide", mk(1, 6144, 0, 0, 0, 0));
    cycle(0, 0, 1, 0, 0, "noupd_start", mk(1, 6144, 0, 0, 0, 0));

    // Speed ramp and obstacle grace period.
    for (int n = 1; n <= 7200; n++) begin
      spd = (6144 + n > 13312) ? 13312 : 6144 + n;
      cycle(0, 1, 0, 0, 0, $sformatf("run%0d", n),
            mk(1, spd, 0, (n >= 180), 0, 0));
    end
    cycle(0, 0, 1, 1, 250, "noupd_hold_obs", mk(1, 13312, 0, 1, 0, 0));

    // Crash with a new high; collide wins over start.
    cycle(0, 1, 1, 1, 250, "crash_new_high", mk(2, 0, 0, 0, 250, 1));

    // Lockout: start ignored through the 60th update.
    for (int k = 1; k <= 60; k++) begin
      cycle(0, 1, 1, 0, 250, $sformatf("lock%0d", k), mk(2, 0, 0, 0, 250, 1));
    end
    cycle(0, 1, 1, 0, 250, "restart1", mk(1, 6144, 1, 0, 250, 0));

    // Second run crashing at an equal score is not a new high.
    for (int n = 1; n <= 5; n++) begin
      cycle(0, 1, 0, 0, 250, $sformatf("run2_%0d", n),
            mk(1, 6144 + n, 0, 0, 250, 0));
    end
    cycle(0, 1, 0, 1, 250, "crash_equal", mk(2, 0, 0, 0, 250, 0));
    for (int k = 1; k <= 60; k++) begin
      cycle(0, 1, 0, 0, 250, $sformatf("lockb%0d", k), mk(2, 0, 0, 0, 250, 0));
    end
    cycle(0, 0, 1, 0, 250, "noupd_in_crash", mk(2, 0, 0, 0, 250, 0));
    cycle(0, 1, 1, 0, 250, "restart2", mk(1, 6144, 1, 0, 250, 0));
    cycle(0, 1, 0, 0, 500, "run3_1", mk(1, 6145, 0, 0, 250, 0));

    // Reset mid-run outranks a simultaneous crash; high score is lost.
    cycle(1, 1, 1, 1, 500, "rst_midrun", mk(0, 0, 0, 0, 0, 0));
    cycle(0, 0, 0, 0, 0, "post_rst_idle", mk(0, 0, 0, 0, 0, 0));
    cycle(0, 1, 1, 0, 0, "start_after_rst", mk(1, 6144, 1, 0, 0, 0));
    cycle(0, 1, 0, 1, 7, "crash_after_rst", mk(2, 0, 0, 0, 7, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
